id_exe_stage_reg: RTL
=====================

Name: id_exe_stage_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection. It captures decoded operands, register indices and control bits from the decode stage, and drives ID_EXE_rs1 and ID_EXE_rs2 to the forwarding unit plus operands and control to EX. It generates the stall request for the PC and IF/ID registers. It inserts bubbles on a hazard or a flush, and keeps a saturating bubble counter for performance debug.

Parameters:
XLEN, 32, operand/PC/immediate width
CNT_W, 16, bubble counter width

Ports:
clk  input  1  pipeline clock, rising-edge
rst  input  1  asynchronous, active-low reset
flush  input  1  branch/jump taken in EX; squash the instruction entering ID/EX
hold  input  1  external freeze (e.g. memory busy); keep current contents
IF_ID_valid  input  1  decode stage holds a real instruction
IF_ID_PC  input  XLEN  PC of decoding instruction
IF_ID_rs1Data  input  XLEN  register file read port 1
IF_ID_rs2Data  input  XLEN  register file read port 2
IF_ID_imm  input  XLEN  generated immediate
IF_ID_rs1  input  5  source index 1
IF_ID_rs2  input  5  source index 2
IF_ID_rd  input  5  destination index
IF_ID_func3  input  3  instruction funct3
IF_ID_ctrl  input  9  {regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[1:0]}
ID_EXE_valid  output  1  EX holds a real instruction
ID_EXE_PC, ID_EXE_rs1Data, ID_EXE_rs2Data, ID_EXE_imm  output  XLEN  registered copies
ID_EXE_rs1, ID_EXE_rs2, ID_EXE_rd  output  5  registered indices (rs1/rs2 feed forwarding unit)
ID_EXE_func3  output  3  registered funct3
ID_EXE_ctrl  output  9  registered control, same packing as IF_ID_ctrl
hazard_stall  output  1  combinational; freeze PC and IF/ID this cycle
bubble_count  output  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst=0, async): all registered outputs 0. ID_EXE_valid=0. bubble_count=0. hazard_stall is therefore 0.
- Hazard detection (combinational): hazard_stall = ID_EXE_valid & ID_EXE_ctrl.memRead & (ID_EXE_rd!=0) & IF_ID_valid & ((ID_EXE_rd==IF_ID_rs1) | (ID_EXE_rd==IF_ID_rs2)).
  - Matches on rs2 even for instructions that do not use rs2; the extra stall is accepted and there is no opcode qualification.
  - hazard_stall is forced to 0 while flush=1, because the dependent instruction is being squashed.
- Update on each rising clk, first matching rule wins:
  1. flush=1: load a bubble. Result: ID_EXE_valid=0, ID_EXE_ctrl=0, ID_EXE_rd=0, ID_EXE_rs1=0, ID_EXE_rs2=0. Data fields may load new values or hold (don't-care). bubble_count is not incremented.
  2. hold=1: all registers keep their values; bubble_count holds. A hazard condition persists unchanged while hold=1.
  3. hazard_stall=1: load a bubble as in rule 1, and bubble_count increments. Next cycle the load sits in EX/MEM, so the hazard clears and the held IF_ID instruction loads.
  4. Otherwise: load all IF_ID_* fields. ID_EXE_valid=IF_ID_valid. If IF_ID_valid=0, ctrl and rd are loaded as 0.
- Latency: 1 cycle from IF_ID inputs to ID_EXE outputs.
- Load-use adds exactly 1 bubble. Back-to-back loads each feeding the next instruction produce 1 bubble per pair.
- bubble_count stops at 2^CNT_W-1 and does not wrap.
- Reset asserted mid-stall: outputs clear immediately; hazard_stall drops in the same cycle.
- Bubbles never write: ctrl=0 implies regWrite=0, memWrite=0, branch=0, jump=0.

Test Plan:
- Reset: hold rst=0 with random inputs, then release -> all outputs 0, bubble_count=0; first valid IF_ID instruction appears on ID_EXE_* after 1 edge.
- Load-use: EX holds lw x5 (memRead=1, rd=5); ID holds add x6,x5,x7 -> hazard_stall=1 for one cycle; next ID_EXE_ctrl=0, ID_EXE_valid=0; bubble_count=1; the add loads on the following edge with ID_EXE_rs1=5.
- No false stall: lw x0 followed by a use of x0 -> hazard_stall=0. lw x5 followed by a use of x6 -> hazard_stall=0. A non-load writing x5 followed by a use of x5 -> hazard_stall=0.
- Flush priority: flush=1 together with a hazard and hold=1 -> hazard_stall=0; ID_EXE_valid=0, ctrl=0; bubble_count unchanged.
- Hold: hold=1 for 3 cycles with changing inputs -> outputs frozen at prior values; bubble_count unchanged; normal loading resumes after hold falls.
- Saturation: with CNT_W=4, force 20 load-use pairs -> bubble_count reaches 15 and stays at 15.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted bubbles.
module id_exe_stage_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             hold,
  input  logic             IF_ID_valid,
  input  logic [XLEN-1:0]  IF_ID_PC,
  input  logic [XLEN-1:0]  IF_ID_rs1Data,
  input  logic [XLEN-1:0]  IF_ID_rs2Data,
  input  logic [XLEN-1:0]  IF_ID_imm,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic [4:0]       IF_ID_rd,
  input  logic [2:0]       IF_ID_func3,
  input  logic [8:0]       IF_ID_ctrl,
  output logic             ID_EXE_valid,
  output logic [XLEN-1:0]  ID_EXE_PC,
  output logic [XLEN-1:0]  ID_EXE_rs1Data,
  output logic [XLEN-1:0]  ID_EXE_rs2Data,
  output logic [XLEN-1:0]  ID_EXE_imm,
  output logic [4:0]       ID_EXE_rs1,
  output logic [4:0]       ID_EXE_rs2,
  output logic [4:0]       ID_EXE_rd,
  output logic [2:0]       ID_EXE_func3,
  output logic [8:0]       ID_EXE_ctrl,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_count
);

  // ctrl packing: {regWrite, memRead, memWrite, memToReg, aluSrc, branch, jump, aluOp[1:0]}
  localparam int MEM_READ_BIT = 7;

  logic load_use;

  assign load_use = ID_EXE_valid && ID_EXE_ctrl[MEM_READ_BIT] && (ID_EXE_rd != 5'd0) &&
                    IF_ID_valid && ((ID_EXE_rd == IF_ID_rs1) || (ID_EXE_rd == IF_ID_rs2));

  // A squashed consumer cannot depend on anything, so flush masks the stall.
  assign hazard_stall = load_use && !flush;

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, making the order of statements irrelevant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ID_EXE_valid   <= 1'b0;
      ID_EXE_PC      <= '0;
      ID_EXE_rs1Data <= '0;
      ID_EXE_rs2Data <= '0;
      ID_EXE_imm     <= '0;
      ID_EXE_rs1     <= '0;
      ID_EXE_rs2     <= '0;
      ID_EXE_rd      <= '0;
      ID_EXE_func3   <= '0;
      ID_EXE_ctrl    <= '0;
      bubble_count   <= '0;
    end else if (flush) begin
      ID_EXE_valid <= 1'b0;
      ID_EXE_ctrl  <= '0;
      ID_EXE_rd    <= '0;
      ID_EXE_rs1   <= '0;
      ID_EXE_rs2   <= '0;
    end else if (!hold) begin
      if (load_use) begin
        ID_EXE_valid <= 1'b0;
        ID_EXE_ctrl  <= '0;
        ID_EXE_rd    <= '0;
        ID_EXE_rs1   <= '0;
        ID_EXE_rs2   <= '0;
        if (bubble_count != {CNT_W{1'b1}})
          bubble_count <= bubble_count + 1'b1;
      end else begin
        ID_EXE_valid   <= IF_ID_valid;
        ID_EXE_PC      <= IF_ID_PC;
        ID_EXE_rs1Data <= IF_ID_rs1Data;
        ID_EXE_rs2Data <= IF_ID_rs2Data;
        ID_EXE_imm     <= IF_ID_imm;
        ID_EXE_rs1     <= IF_ID_rs1;
        ID_EXE_rs2     <= IF_ID_rs2;
        ID_EXE_func3   <= IF_ID_func3;
        // An invalid slot must never look like it writes anything.
        ID_EXE_rd      <= IF_ID_valid ? IF_ID_rd : 5'd0;
        ID_EXE_ctrl    <= IF_ID_valid ? IF_ID_ctrl : 9'd0;
      end
    end
  end

endmodule
